// File: rtl/fabric_config_spi_rx.sv
// SPI mode-0 slave receiver: assembles WORD_WIDTH-bit words for the fabric config controller.
// Optional running word checksum enabled by defining FABRIC_CFG_SPI_CHECKSUM_EN.
module fabric_config_spi_rx #(
    parameter int WORD_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  clk_gated,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  cs_ni,
    input  logic                  mosi_i,
    output logic [WORD_WIDTH-1:0] bitstream_data_o,
    output logic                  bitstream_valid_o,
    output logic                  active_o,
    output logic                  frag_err_o,
    output logic [15:0]           word_count_o,
    output logic [WORD_WIDTH-1:0] checksum_o
);
    localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, cs_rise, cs_fall;

    logic [CNT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] shreg, shift_next;
    logic                  start, stop, shift_en, word_done;

    // Identical chains keep sclk, cs and mosi mutually aligned after synchronization.
    always_ff @(posedge clk_gated or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_ni};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk_gated or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        stop       = 1'b0;
        shift_en   = 1'b0;
        shift_next = shreg;
        if (MSB_FIRST != 0) shift_next = {shreg[WORD_WIDTH-2:0], mosi_s};
        else                shift_next = {mosi_s, shreg[WORD_WIDTH-1:1]};
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    start   = 1'b1;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                // cs release wins over a coincident sclk rise
                if (cs_rise) begin
                    stop    = 1'b1;
                    state_d = S_IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign word_done = shift_en && (bit_cnt == CNT_W'(WORD_WIDTH - 1));
    assign active_o  = (state_q == S_RECV);

    always_ff @(posedge clk_gated or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt           <= '0;
            shreg             <= '0;
            bitstream_data_o  <= '0;
            bitstream_valid_o <= 1'b0;
            frag_err_o        <= 1'b0;
            word_count_o      <= '0;
        end else begin
            bitstream_valid_o <= word_done;
            if (start) begin
                bit_cnt      <= '0;
                shreg        <= '0;
                word_count_o <= '0;
                frag_err_o   <= 1'b0;
            end else if (stop) begin
                frag_err_o <= (bit_cnt != '0);
                bit_cnt    <= '0;
                shreg      <= '0;
            end else if (shift_en) begin
                shreg   <= shift_next;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) begin
                    bitstream_data_o <= shift_next;
                    if (word_count_o != 16'hFFFF) word_count_o <= word_count_o + 16'd1;
                end
            end
        end
    end

`ifdef FABRIC_CFG_SPI_CHECKSUM_EN
    // Accumulates while the valid pulse is up, so the sum covers that word one cycle later.
    always_ff @(posedge clk_gated or negedge rst_ni) begin
        if (!rst_ni)                checksum_o <= '0;
        else if (start)             checksum_o <= '0;
        else if (bitstream_valid_o) checksum_o <= checksum_o + bitstream_data_o;
    end
`else
    assign checksum_o = '0;
`endif

endmodule
